// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buffer
// Brief    : IF/ID decoupling FIFO of {PC, instruction} pairs with valid/ready
//            handshakes, taken-branch flush and NOP output when empty.
//            Optional stall counter enabled by defining IF_ID_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_buffer #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [AW-1:0]            in_pc,
    input  logic [AW-1:0]            in_instr,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [AW-1:0]            out_pc,
    output logic [AW-1:0]            out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int             PW         = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_COUNT = (PW+1)'(DEPTH);

    logic [AW-1:0] pc_mem    [DEPTH];
    logic [AW-1:0] instr_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push;
    logic          pop;

    // in_ready is a function of the registered count only, so out_ready never
    // reaches it combinationally.
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign occupancy = count;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as-is; the zeroed count hides stale entries.
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= in_pc;
                instr_mem[wr_ptr] <= in_instr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_buffer
// Brief    : Scoreboard bench for if_id_buffer with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic [1:0]  occupancy;
`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } pair_t;

    pair_t sb[$];
    int    checks = 0;
    int    errors = 0;

    if_id_buffer #(.DEPTH(2), .AW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .occupancy (occupancy)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor/scoreboard: sampled mid-cycle, ahead of the edge that acts on it.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop: got pc %h expected none", out_pc);
                    end else begin
                        pair_t e;
                        e = sb.pop_front();
                        check("pop_pc", out_pc, e.pc);
                        check("pop_instr", out_instr, e.instr);
                    end
                end
                if (in_valid && in_ready) begin
                    pair_t n;
                    n.pc    = in_pc;
                    n.instr = in_instr;
                    sb.push_back(n);
                end
            end
        end
    end

    always @(posedge rst) sb.delete();

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_in_ready", 32'(in_ready), 32'd1);
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_out_instr", out_instr, 32'h0);
            check("idle_occ", 32'(occupancy), 32'd0);
        end

        // Single push with decode ready
        in_valid = 1'b1; in_pc = 32'h4; in_instr = 32'h2008_0005; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_pc", out_pc, 32'h4);
        check("single_instr", out_instr, 32'h2008_0005);
        check("single_occ1", 32'(occupancy), 32'd1);
        tick();
        check("single_occ0", 32'(occupancy), 32'd0);
        check("single_empty_instr", out_instr, 32'h0);

        // Fill with decode stalled, third word held
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h4; in_instr = 32'hA000_0004;
        tick();
        check("fill_ready1", 32'(in_ready), 32'd1);
        in_pc = 32'h8; in_instr = 32'hA000_0008;
        tick();
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_occ", 32'(occupancy), 32'd2);
        in_pc = 32'hC; in_instr = 32'hA000_000C;
        tick();
        check("held_ready", 32'(in_ready), 32'd0);
        check("held_occ", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        tick();
        check("after_pop_ready", 32'(in_ready), 32'd1);
        check("after_pop_occ", 32'(occupancy), 32'd1);
        tick();
        check("pushpop_occ", 32'(occupancy), 32'd1);
        in_valid = 1'b0;
        tick();
        check("drain_occ", 32'(occupancy), 32'd0);

        // Streaming with wrap-around
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'h100 + 32'(4 * i);
            in_instr = 32'h2000_0000 | 32'(i);
            tick();
            check("stream_occ", 32'(occupancy), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_occ", 32'(occupancy), 32'd0);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        // Flush while full with simultaneous push attempt
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h10; in_instr = 32'hB000_0010;
        tick();
        in_pc = 32'h14; in_instr = 32'hB000_0014;
        tick();
        check("pre_flush_occ", 32'(occupancy), 32'd2);
        flush = 1'b1; in_pc = 32'h18; in_instr = 32'hB000_0018;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_instr", out_instr, 32'h0);
        check("flush_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'hB000_0040; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_flush_pc", out_pc, 32'h40);
        tick();
        check("post_flush_occ", 32'(occupancy), 32'd0);

        // Flush from partial state discards an accepted-looking push
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h50; in_instr = 32'hC000_0050;
        tick();
        flush = 1'b1; in_pc = 32'h54; in_instr = 32'hC000_0054;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_partial_occ", 32'(occupancy), 32'd0);
        check("flush_partial_instr", out_instr, 32'h0);

        // Asynchronous reset mid-operation
        in_valid = 1'b1; in_pc = 32'h60; in_instr = 32'hD000_0060;
        tick();
        in_pc = 32'h64; in_instr = 32'hD000_0064;
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_occ", 32'(occupancy), 32'd0);
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_pc", out_pc, 32'h0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef IF_ID_STALL_CNT_EN
        // Stall counter: 7 blocked cycles, survives flush, cleared by reset
        check("stall_init", stall_cnt, 32'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h10; in_instr = 32'hE000_0010;
        tick();
        in_pc = 32'h14; in_instr = 32'hE000_0014;
        tick();
        check("stall_filled", stall_cnt, 32'd0);
        in_pc = 32'h18; in_instr = 32'hE000_0018;
        repeat (7) tick();
        check("stall_seven", stall_cnt, 32'd7);
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stall_after_flush", stall_cnt, 32'd7);
        check("stall_flush_occ", 32'(occupancy), 32'd0);
        rst = 1'b1;
        #1;
        check("stall_after_rst", stall_cnt, 32'd0);
        tick();
        rst = 1'b0;
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
